// File: rtl/cpu_ask2_pio_bidir.sv
// Bidirectional parallel I/O slave for the ASK2 Nios Avalon-MM bus: per-bit direction,
// atomic set/clear, two-flop input sync; edge capture and irq only with CPU_ASK2_PIO_BIDIR_IRQ_EN.
module cpu_ask2_pio_bidir #(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] RESET_OUT = 32'd0,
    parameter logic [31:0] RESET_DIR = 32'd0,
    parameter int unsigned EDGE_TYPE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
    localparam logic [WIDTH-1:0] RST_OUT_C = RESET_OUT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_DIR_C = RESET_DIR[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};

    logic             wr_s;
    logic [WIDTH-1:0] wdata_s;
    logic             unused_wdata_s;
    logic [WIDTH-1:0] data_out_r;
    logic [WIDTH-1:0] data_dir_r;
    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [31:0]      rd_s;
    logic [31:0]      readdata_r;

    assign wr_s           = chipselect & ~write_n;
    assign wdata_s        = writedata[WIDTH-1:0];
    assign unused_wdata_s = ^writedata;

    // Output register: full load, atomic set and atomic clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r <= RST_OUT_C;
        end else if (wr_s && address == ADDR_DATA) begin
            data_out_r <= wdata_s;
        end else if (wr_s && address == ADDR_OUTSET) begin
            data_out_r <= data_out_r | wdata_s;
        end else if (wr_s && address == ADDR_OUTCLR) begin
            data_out_r <= data_out_r & ~wdata_s;
        end
    end

    // Direction register, 1 = drive the pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_dir_r <= RST_DIR_C;
        end else if (wr_s && address == ADDR_DIR) begin
            data_dir_r <= wdata_s;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign bidir_port[i] = data_dir_r[i] ? data_out_r[i] : 1'bz;
    end

    // Two-flop synchroniser on the pad value (driven pins loop back too)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= ZERO_C;
            sync2_r <= ZERO_C;
        end else begin
            sync1_r <= bidir_port;
            sync2_r <= sync1_r;
        end
    end

`ifdef CPU_ASK2_PIO_BIDIR_IRQ_EN
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] edge_cap_r;
    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;

    // Edge detection on the synchronised pins, polarity chosen at build time
    always_comb begin
        edge_s = ZERO_C;
        case (EDGE_TYPE)
            32'd0:   edge_s = sync2_r & ~prev_r;
            32'd1:   edge_s = ~sync2_r & prev_r;
            default: edge_s = (sync2_r & ~prev_r) | (~sync2_r & prev_r);
        endcase
    end

    // Write-one-to-clear mask for the capture register
    always_comb begin
        clr_s = ZERO_C;
        if (wr_s && address == ADDR_EDGE) begin
            clr_s = wdata_s;
        end else begin
            clr_s = ZERO_C;
        end
    end

    // Capture register: a fresh edge beats a same-cycle clear of that bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r     <= ZERO_C;
            edge_cap_r <= ZERO_C;
            irq_mask_r <= ZERO_C;
        end else begin
            prev_r     <= sync2_r;
            edge_cap_r <= (edge_cap_r & ~clr_s) | edge_s;
            if (wr_s && address == ADDR_MASK) begin
                irq_mask_r <= wdata_s;
            end
        end
    end

    assign irq = |(edge_cap_r & irq_mask_r);
`else
    assign irq = 1'b0;
`endif

    // Read mux; unused upper bits and unmapped addresses return zero
    always_comb begin
        rd_s = 32'd0;
        case (address)
            ADDR_DATA: rd_s[WIDTH-1:0] = sync2_r;
            ADDR_DIR:  rd_s[WIDTH-1:0] = data_dir_r;
`ifdef CPU_ASK2_PIO_BIDIR_IRQ_EN
            ADDR_MASK: rd_s[WIDTH-1:0] = irq_mask_r;
            ADDR_EDGE: rd_s[WIDTH-1:0] = edge_cap_r;
`endif
            default:   rd_s = 32'd0;
        endcase
    end

    // Read data is refreshed every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_s;
        end
    end

    assign readdata = readdata_r;

endmodule

// File: tb/tb_cpu_ask2_pio_bidir.sv
// Scoreboard bench for cpu_ask2_pio_bidir: a pad-history reference model predicts readdata,
// irq and driven pins each cycle; a negedge monitor pops and compares.
module tb_cpu_ask2_pio_bidir;
    localparam int W  = 8;
    localparam int ET = 0;
`ifdef CPU_ASK2_PIO_BIDIR_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;
    wire  [W-1:0]  pins;
    logic [W-1:0]  tb_oe;
    logic [W-1:0]  tb_val;

    for (genvar i = 0; i < W; i++) begin : g_drv
        assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    always #5 clk = ~clk;

    cpu_ask2_pio_bidir #(
        .WIDTH(W), .RESET_OUT(32'h05), .RESET_DIR(32'h0F), .EDGE_TYPE(ET)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .bidir_port(pins)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        logic [31:0] msk;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = -1;
    logic [W-1:0] hist[int];
    logic [W-1:0] m_out, m_dir, m_mask, m_ecap;

    always @(posedge clk) if (reset_n) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] pad_at(input int j);
        return hist.exists(j) ? hist[j] : '0;
    endfunction

    // monitor: compares every expectation queued for the edge just passed
    always @(negedge clk) begin : mon
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            if (e.cyc != cyc)
                chk("sb_order", e.cyc, cyc);
            else if (e.kind == 0)
                chk("readdata", readdata, e.exp);
            else if (e.kind == 1)
                chk("irq", {31'd0, irq}, e.exp);
            else
                chk("pins", {24'd0, pins} & e.msk, e.exp & e.msk);
        end
    end

    // one bus cycle: drive at negedge, predict the effect of the next posedge
    task automatic tick(input logic [2:0] a, input logic cs, input logic wr,
                        input logic [31:0] wd, input logic [W-1:0] ext);
        int          j;
        logic [W-1:0] wv, clr, now_p, bef_p, ed;
        logic [31:0] rexp;
        j          = cyc + 1;
        address    = a;
        chipselect = cs;
        write_n    = ~wr;
        writedata  = wd;
        tb_val     = ext;
        hist[j]    = (m_dir & m_out) | (~m_dir & ext);
        case (a)
            3'd0:    rexp = {24'd0, pad_at(j - 2)};
            3'd1:    rexp = {24'd0, m_dir};
            3'd2:    rexp = IRQ_EN ? {24'd0, m_mask} : 32'd0;
            3'd3:    rexp = IRQ_EN ? {24'd0, m_ecap} : 32'd0;
            default: rexp = 32'd0;
        endcase
        wv  = wd[W-1:0];
        clr = '0;
        if (cs && wr) begin
            case (a)
                3'd0:    m_out = wv;
                3'd1:    m_dir = wv;
                3'd2:    m_mask = wv;
                3'd3:    clr = wv;
                3'd4:    m_out = m_out | wv;
                3'd5:    m_out = m_out & ~wv;
                default: ;
            endcase
        end
        now_p = pad_at(j - 2);
        bef_p = pad_at(j - 3);
        case (ET)
            0:       ed = now_p & ~bef_p;
            1:       ed = ~now_p & bef_p;
            default: ed = now_p ^ bef_p;
        endcase
        m_ecap = (m_ecap & ~clr) | ed;
        sbq.push_back('{j, 0, rexp, 32'hFFFF_FFFF});
        sbq.push_back('{j, 1, {31'd0, IRQ_EN && ((m_ecap & m_mask) != '0)}, 32'h1});
        sbq.push_back('{j, 2, {24'd0, m_dir & m_out}, {24'd0, m_dir}});
        @(posedge clk);
        #1 tb_oe = ~m_dir;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ext_r;
        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        tb_oe = 8'hF0; tb_val = 8'hA0;
        m_out = 8'h05; m_dir = 8'h0F; m_mask = 8'h00; m_ecap = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pins", {24'd0, pins}, 32'hA5);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        tb_val = 8'h00;
        @(negedge clk);
        chk("rst_pins_low", {24'd0, pins}, 32'h05);
        reset_n = 1'b1;

        // reset-release rising edges on pins 0 and 2 then software clear
        repeat (4) tick(3'd3, 1'b0, 1'b0, 32'd0, 8'h00);
        chk("release_edges", readdata, IRQ_EN ? 32'h05 : 32'h0);
        tick(3'd3, 1'b1, 1'b1, 32'hFF, 8'h00);

        // direction and data
        tick(3'd1, 1'b1, 1'b1, 32'hFF, 8'h00);
        tick(3'd0, 1'b1, 1'b1, 32'hA5, 8'h00);
        chk("pins_a5", {24'd0, pins}, 32'hA5);
        tick(3'd4, 1'b1, 1'b1, 32'h02, 8'h00);
        chk("pins_a7", {24'd0, pins}, 32'hA7);
        tick(3'd5, 1'b1, 1'b1, 32'h80, 8'h00);
        chk("pins_27", {24'd0, pins}, 32'h27);
        tick(3'd7, 1'b0, 1'b0, 32'd0, 8'h00);
        tick(3'd7, 1'b0, 1'b0, 32'd0, 8'h00);
        tick(3'd0, 1'b0, 1'b0, 32'd0, 8'h00);
        chk("data_loopback", readdata, 32'h27);

        // edge / irq on pin 0
        tick(3'd1, 1'b1, 1'b1, 32'h00, 8'h00);
        repeat (4) tick(3'd3, 1'b1, 1'b0, 32'd0, 8'h00);
        tick(3'd3, 1'b1, 1'b1, 32'hFF, 8'h00);
        tick(3'd2, 1'b1, 1'b1, 32'h01, 8'h00);
        repeat (2) tick(3'd3, 1'b0, 1'b0, 32'd0, 8'h00);
        tick(3'd3, 1'b0, 1'b0, 32'd0, 8'h01);
        chk("irq_k0", {31'd0, irq}, 32'd0);
        tick(3'd3, 1'b0, 1'b0, 32'd0, 8'h01);
        chk("irq_k1", {31'd0, irq}, 32'd0);
        tick(3'd3, 1'b0, 1'b0, 32'd0, 8'h01);
        chk("irq_k2", {31'd0, irq}, {31'd0, IRQ_EN});
        tick(3'd3, 1'b0, 1'b0, 32'd0, 8'h01);
        chk("edge_read", readdata, IRQ_EN ? 32'h01 : 32'h0);
        tick(3'd3, 1'b1, 1'b1, 32'h01, 8'h01);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // clear collides with a pin 1 edge landing on the same edge
        tick(3'd7, 1'b0, 1'b0, 32'd0, 8'h03);
        tick(3'd7, 1'b0, 1'b0, 32'd0, 8'h03);
        tick(3'd3, 1'b1, 1'b1, 32'h02, 8'h03);
        tick(3'd3, 1'b0, 1'b0, 32'd0, 8'h03);
        chk("collision", readdata, IRQ_EN ? 32'h02 : 32'h0);

        // masked edge, width limit, unmapped address
        tick(3'd2, 1'b1, 1'b1, 32'h00, 8'h03);
        tick(3'd3, 1'b1, 1'b1, 32'hFF, 8'h03);
        repeat (4) tick(3'd7, 1'b0, 1'b0, 32'd0, 8'h07);
        tick(3'd3, 1'b0, 1'b0, 32'd0, 8'h07);
        chk("masked_edge", readdata, IRQ_EN ? 32'h04 : 32'h0);
        chk("masked_irq", {31'd0, irq}, 32'd0);
        tick(3'd1, 1'b1, 1'b1, 32'hFFFF_FF00, 8'h07);
        tick(3'd1, 1'b0, 1'b0, 32'd0, 8'h07);
        chk("dir_width", readdata, 32'd0);
        tick(3'd6, 1'b1, 1'b1, 32'hFFFF_FFFF, 8'h07);
        tick(3'd6, 1'b0, 1'b0, 32'd0, 8'h07);
        chk("addr6", readdata, 32'd0);

        // randomised traffic against the model
        ext_r = 8'h07;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) ext_r = W'($urandom);
            tick(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, ext_r);
        end
        repeat (4) tick(3'd3, 1'b0, 1'b0, 32'd0, ext_r);
        @(negedge clk);
        chk("sb_drain", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
